// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Bundles the writeback request channels (ALU and memory), the
//            destination-reservation channel, the read-hazard taps and the
//            register-file write port driven by regfile_write_arbiter.
// Ports    : master - execute/memory/issue/read side (drives requests,
//                     observes readies, stall and write port)
//            slave  - the arbiter itself
// Revision : 1.0  initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
);
    // ALU writeback request
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    // Memory-load writeback request
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    // Destination reservation from issue logic
    logic                  reserve_valid;
    logic [ADDR_WIDTH-1:0] reserve_addr;
    logic                  reserve_ready;
    // Read-side hazard detection
    logic [ADDR_WIDTH-1:0] AAddress;
    logic [ADDR_WIDTH-1:0] BAddress;
    logic                  a_use;
    logic                  b_use;
    logic                  stall;
    // Register file write port and status
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] DataIn;
    logic [NUM_REGS-1:0]   pending;
    logic                  grant_src;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output reserve_valid, reserve_addr,
        output AAddress, BAddress, a_use, b_use,
        input  alu_ready, mem_ready, reserve_ready, stall,
        input  RegWrite, WriteAddress, DataIn, pending, grant_src
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  reserve_valid, reserve_addr,
        input  AAddress, BAddress, a_use, b_use,
        output alu_ready, mem_ready, reserve_ready, stall,
        output RegWrite, WriteAddress, DataIn, pending, grant_src
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register file's single write port between the ALU
//            and memory-load writeback paths using round-robin arbitration,
//            and keeps a per-register pending scoreboard that stalls reads of
//            registers whose result has not yet been written.
// Ports    : clk   - system clock, all state on the rising edge
//            reset - synchronous active-high reset
//            bus   - regfile_write_arbiter_if.slave (requests, reservation,
//                    read taps, registered write port, scoreboard, grant_src)
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16   // must equal 2**ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    // Round-robin state: which source won the most recent grant
    src_t                  r_last_grant;
    src_t                  w_last_grant_next;

    logic                  w_alu_grant;
    logic                  w_mem_grant;
    logic                  w_reserve_accept;

    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_write_addr;
    logic [DATA_WIDTH-1:0] r_write_data;
    src_t                  r_grant_src;

    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_pending_next;

    // ------------------------------------------------------------------
    // Arbitration and round-robin next state. Nothing is granted while
    // reset is high so no request can be accepted and then lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_grant       = 1'b0;
        w_mem_grant       = 1'b0;
        w_last_grant_next = r_last_grant;
        if (!reset) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (r_last_grant == SRC_MEM) begin
                    w_alu_grant = 1'b1;
                end else begin
                    w_mem_grant = 1'b1;
                end
            end else begin
                w_alu_grant = bus.alu_valid;
                w_mem_grant = bus.mem_valid;
            end
        end
        // Idle cycles leave the round-robin pointer untouched
        if (w_alu_grant) begin
            w_last_grant_next = SRC_ALU;
        end else if (w_mem_grant) begin
            w_last_grant_next = SRC_MEM;
        end
    end

    // A register already awaiting its result cannot be reserved again
    assign w_reserve_accept = ~reset & bus.reserve_valid & ~r_pending[bus.reserve_addr];

    // ------------------------------------------------------------------
    // Scoreboard next state. The clear happens on the same edge the
    // register file captures the write; a reservation landing on that
    // edge for the same register is applied afterwards so it wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_pending_next = r_pending;
        if (r_reg_write) begin
            w_pending_next[r_write_addr] = 1'b0;
        end
        if (w_reserve_accept) begin
            w_pending_next[bus.reserve_addr] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= SRC_MEM;   // ALU wins the first contended cycle
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Write port and scoreboard registers. Address/data/source only load
    // on a grant so they hold their last values across idle cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_grant_src  <= SRC_ALU;
            r_pending    <= '0;
        end else begin
            r_reg_write <= w_alu_grant | w_mem_grant;
            r_pending   <= w_pending_next;
            if (w_alu_grant) begin
                r_write_addr <= bus.alu_addr;
                r_write_data <= bus.alu_data;
                r_grant_src  <= SRC_ALU;
            end else if (w_mem_grant) begin
                r_write_addr <= bus.mem_addr;
                r_write_data <= bus.mem_data;
                r_grant_src  <= SRC_MEM;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.alu_ready     = w_alu_grant;
    assign bus.mem_ready     = w_mem_grant;
    assign bus.reserve_ready = w_reserve_accept;
    // No bypass: a used operand whose register is pending always stalls
    assign bus.stall         = ~reset & ((bus.a_use & r_pending[bus.AAddress]) |
                                         (bus.b_use & r_pending[bus.BAddress]));
    assign bus.RegWrite      = r_reg_write;
    assign bus.WriteAddress  = r_write_addr;
    assign bus.DataIn        = r_write_data;
    assign bus.pending       = r_pending;
    assign bus.grant_src     = r_grant_src;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter. Directed scenario
//            tasks plus a randomized run, all compared against a behavioural
//            model (scoreboard bit-vector, grant history, register array).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;

    logic clk;
    logic reset;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stand-in register file: captures on RegWrite, ignores writes while reset
    logic [DW-1:0] rf [NR];
    logic          rf_init_done = 1'b0;
    always @(posedge clk) begin
        if (!rf_init_done) begin
            for (int i = 0; i < NR; i++) rf[i] <= '0;
        end else if (bus.RegWrite && !reset) begin
            rf[bus.WriteAddress] <= bus.DataIn;
        end
    end

    // ---------------- behavioural model ----------------
    logic [NR-1:0] m_pending;
    logic          m_wr_valid;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic          m_wr_src;
    logic [DW-1:0] m_rf [NR];
    bit            grant_log [$];   // 0 = ALU, 1 = MEM
    bit            got_alu, got_mem;

    task automatic model_reset();
        m_pending  = '0;
        m_wr_valid = 1'b0;
        m_wr_addr  = '0;
        m_wr_data  = '0;
        m_wr_src   = 1'b0;
        grant_log.delete();
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.reserve_valid = 0; bus.reserve_addr = '0;
        bus.AAddress = '0; bus.BAddress = '0; bus.a_use = 0; bus.b_use = 0;
    endtask

    // Called with inputs already driven (just after a falling edge). Checks
    // combinational outputs, advances the model across the next rising edge
    // and checks registered outputs afterwards.
    task automatic cycle_check(input string tag);
        bit e_ar, e_mr, e_rr, e_st, alu_wins;
        logic [NR-1:0] nxt;
        #1;
        alu_wins = (grant_log.size() == 0) ? 1'b1 : (grant_log[$] == 1'b1);
        e_ar = bus.alu_valid && (!bus.mem_valid || alu_wins);
        e_mr = bus.mem_valid && (!bus.alu_valid || !alu_wins);
        e_rr = bus.reserve_valid && !m_pending[bus.reserve_addr];
        e_st = (bus.a_use && m_pending[bus.AAddress]) || (bus.b_use && m_pending[bus.BAddress]);
        checks += 4;
        if (bus.alu_ready !== e_ar) begin failures++; $display("FAIL %s alu_ready got=%0b exp=%0b", tag, bus.alu_ready, e_ar); end
        if (bus.mem_ready !== e_mr) begin failures++; $display("FAIL %s mem_ready got=%0b exp=%0b", tag, bus.mem_ready, e_mr); end
        if (bus.reserve_ready !== e_rr) begin failures++; $display("FAIL %s reserve_ready got=%0b exp=%0b", tag, bus.reserve_ready, e_rr); end
        if (bus.stall !== e_st) begin failures++; $display("FAIL %s stall got=%0b exp=%0b", tag, bus.stall, e_st); end
        got_alu = e_ar;
        got_mem = e_mr;
        // model across the edge: retire outstanding write, then reserve (set wins)
        nxt = m_pending;
        if (m_wr_valid) begin
            nxt[m_wr_addr]  = 1'b0;
            m_rf[m_wr_addr] = m_wr_data;
        end
        if (e_rr) nxt[bus.reserve_addr] = 1'b1;
        m_pending = nxt;
        m_wr_valid = e_ar || e_mr;
        if (e_ar) begin
            m_wr_addr = bus.alu_addr; m_wr_data = bus.alu_data; m_wr_src = 1'b0;
            grant_log.push_back(1'b0);
        end else if (e_mr) begin
            m_wr_addr = bus.mem_addr; m_wr_data = bus.mem_data; m_wr_src = 1'b1;
            grant_log.push_back(1'b1);
        end
        if (grant_log.size() > 8) void'(grant_log.pop_front());
        @(posedge clk); #1;
        checks += 5;
        if (bus.RegWrite !== m_wr_valid) begin failures++; $display("FAIL %s RegWrite got=%0b exp=%0b", tag, bus.RegWrite, m_wr_valid); end
        if (bus.WriteAddress !== m_wr_addr) begin failures++; $display("FAIL %s WriteAddress got=%0d exp=%0d", tag, bus.WriteAddress, m_wr_addr); end
        if (bus.DataIn !== m_wr_data) begin failures++; $display("FAIL %s DataIn got=%h exp=%h", tag, bus.DataIn, m_wr_data); end
        if (bus.grant_src !== m_wr_src) begin failures++; $display("FAIL %s grant_src got=%0b exp=%0b", tag, bus.grant_src, m_wr_src); end
        if (bus.pending !== m_pending) begin failures++; $display("FAIL %s pending got=%h exp=%h", tag, bus.pending, m_pending); end
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            checks++;
            if ({bus.alu_ready, bus.mem_ready, bus.reserve_ready, bus.stall} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs got=%b exp=0000", {bus.alu_ready, bus.mem_ready, bus.reserve_ready, bus.stall});
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RegWrite !== 1'b0 || bus.pending !== 16'h0000) begin
                failures++;
                $display("FAIL reset_state RegWrite=%0b pending=%h exp 0/0000", bus.RegWrite, bus.pending);
            end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        bus.alu_valid = 1; bus.alu_addr = 4'd1; bus.alu_data = 16'h0A0A;
        bus.mem_valid = 1; bus.mem_addr = 4'd2; bus.mem_data = 16'h0B0B;
        bus.a_use = 1; bus.AAddress = 4'd1;
        apply_reset(2);
        @(negedge clk);
        cycle_check("first_grant");
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.grant_src !== 1'b0 || bus.DataIn !== 16'h0A0A) begin
            failures++;
            $display("FAIL first_grant_alu RegWrite=%0b src=%0b data=%h exp 1/0/0a0a", bus.RegWrite, bus.grant_src, bus.DataIn);
        end
        @(negedge clk); idle(); cycle_check("rst_drain");
    endtask

    task automatic test_single_alu();
        @(negedge clk); idle(); bus.reserve_valid = 1; bus.reserve_addr = 4'd3; cycle_check("res_r3");
        @(negedge clk); idle(); bus.alu_valid = 1; bus.alu_addr = 4'd3; bus.alu_data = 16'h1234;
        cycle_check("alu_r3");
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddress !== 4'd3 || bus.DataIn !== 16'h1234 ||
            bus.grant_src !== 1'b0 || bus.pending[3] !== 1'b1) begin
            failures++;
            $display("FAIL single_alu_write we=%0b addr=%0d data=%h src=%0b p3=%0b exp 1/3/1234/0/1",
                     bus.RegWrite, bus.WriteAddress, bus.DataIn, bus.grant_src, bus.pending[3]);
        end
        @(negedge clk); idle(); bus.AAddress = 4'd3; bus.a_use = 1; cycle_check("retire_r3");
        checks++;
        if (bus.pending[3] !== 1'b0 || rf[bus.AAddress] !== 16'h1234) begin
            failures++;
            $display("FAIL single_alu_readback p3=%0b A=%h exp 0/1234", bus.pending[3], rf[bus.AAddress]);
        end
    endtask

    task automatic test_contention();
        bit exp_src;
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            bus.alu_valid = 1; bus.alu_addr = 4'd1; bus.alu_data = 16'h0011;
            bus.mem_valid = 1; bus.mem_addr = 4'd2; bus.mem_data = 16'h0022;
            cycle_check("contend");
            exp_src = (i % 2 == 1);
            checks++;
            if (bus.RegWrite !== 1'b1 || bus.grant_src !== exp_src ||
                bus.DataIn !== (exp_src ? 16'h0022 : 16'h0011)) begin
                failures++;
                $display("FAIL contention_%0d we=%0b src=%0b data=%h exp_src=%0b", i, bus.RegWrite, bus.grant_src, bus.DataIn, exp_src);
            end
        end
        @(negedge clk); idle(); cycle_check("contend_drain");
    endtask

    task automatic test_hazard();
        @(negedge clk); idle(); bus.reserve_valid = 1; bus.reserve_addr = 4'd5; cycle_check("res_r5");
        @(negedge clk); idle(); bus.AAddress = 4'd5; bus.a_use = 1;
        #1; checks++;
        if (bus.stall !== 1'b1) begin failures++; $display("FAIL hazard_stall_set got=%0b exp=1", bus.stall); end
        cycle_check("haz_wait");
        @(negedge clk); idle(); bus.AAddress = 4'd5; bus.a_use = 1;
        bus.mem_valid = 1; bus.mem_addr = 4'd5; bus.mem_data = 16'hBEEF;
        cycle_check("haz_memwr");
        @(negedge clk); idle(); bus.AAddress = 4'd5; bus.a_use = 1;
        #1; checks++;
        if (bus.stall !== 1'b1) begin failures++; $display("FAIL hazard_stall_during_write got=%0b exp=1", bus.stall); end
        cycle_check("haz_retire");
        @(negedge clk); idle(); bus.AAddress = 4'd5; bus.a_use = 1;
        #1; checks++;
        if (bus.stall !== 1'b0 || rf[bus.AAddress] !== 16'hBEEF) begin
            failures++; $display("FAIL hazard_release stall=%0b A=%h exp 0/beef", bus.stall, rf[bus.AAddress]);
        end
        bus.reserve_valid = 1; bus.reserve_addr = 4'd5;
        cycle_check("haz_rereserve");
        @(negedge clk); idle(); bus.AAddress = 4'd5; bus.a_use = 0; bus.BAddress = 4'd5; bus.b_use = 0;
        #1; checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL hazard_unused_operand got=%0b exp=0", bus.stall); end
        cycle_check("haz_unused");
        @(negedge clk); idle(); bus.BAddress = 4'd5; bus.b_use = 1;
        #1; checks++;
        if (bus.stall !== 1'b1) begin failures++; $display("FAIL hazard_b_operand got=%0b exp=1", bus.stall); end
        cycle_check("haz_b");
    endtask

    task automatic test_scoreboard();
        @(negedge clk); idle(); bus.reserve_valid = 1; bus.reserve_addr = 4'd7; cycle_check("res_r7");
        @(negedge clk); idle(); bus.reserve_valid = 1; bus.reserve_addr = 4'd7;
        #1; checks++;
        if (bus.reserve_ready !== 1'b0) begin failures++; $display("FAIL double_reserve got=%0b exp=0", bus.reserve_ready); end
        cycle_check("res_r7_again");
        @(negedge clk); idle(); bus.alu_valid = 1; bus.alu_addr = 4'd7; bus.alu_data = 16'hAA55; cycle_check("wr_r7");
        @(negedge clk); idle(); cycle_check("retire_r7");
        // R7 is now clear: write it again and reserve it on the retiring edge
        @(negedge clk); idle(); bus.alu_valid = 1; bus.alu_addr = 4'd7; bus.alu_data = 16'h1357; cycle_check("wr_r7_free");
        @(negedge clk); idle(); bus.reserve_valid = 1; bus.reserve_addr = 4'd7;
        #1; checks++;
        if (bus.reserve_ready !== 1'b1) begin failures++; $display("FAIL reserve_on_retire_ready got=%0b exp=1", bus.reserve_ready); end
        cycle_check("set_wins");
        checks++;
        if (bus.pending[7] !== 1'b1 || rf[7] !== 16'h1357) begin
            failures++; $display("FAIL set_wins p7=%0b rf7=%h exp 1/1357", bus.pending[7], rf[7]);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] old9;
        @(negedge clk); idle(); bus.reserve_valid = 1; bus.reserve_addr = 4'd9; cycle_check("res_r9");
        old9 = rf[9];
        @(negedge clk); idle(); bus.alu_valid = 1; bus.alu_addr = 4'd9; bus.alu_data = 16'hDEAD; cycle_check("wr_r9");
        @(negedge clk); idle(); reset = 1'b1;
        #1; checks++;
        if ({bus.alu_ready, bus.mem_ready, bus.reserve_ready, bus.stall} !== 4'b0000) begin
            failures++; $display("FAIL midreset_outputs got=%b exp=0000", {bus.alu_ready, bus.mem_ready, bus.reserve_ready, bus.stall});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.pending !== 16'h0000 || rf[9] !== old9) begin
            failures++; $display("FAIL midreset_discard we=%0b pending=%h r9=%h exp 0/0000/%h", bus.RegWrite, bus.pending, rf[9], old9);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk); idle(); cycle_check("after_midreset");
    endtask

    task automatic test_random();
        apply_reset(1);
        idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.alu_valid && !got_alu) begin
                if ($urandom_range(0, 7) == 0) bus.alu_valid = 0;   // withdraw, never change
            end else begin
                bus.alu_valid = ($urandom_range(0, 2) != 0);
                bus.alu_addr  = AW'($urandom_range(0, NR - 1));
                bus.alu_data  = DW'($urandom);
            end
            if (bus.mem_valid && !got_mem) begin
                if ($urandom_range(0, 7) == 0) bus.mem_valid = 0;
            end else begin
                bus.mem_valid = ($urandom_range(0, 2) != 0);
                bus.mem_addr  = AW'($urandom_range(0, NR - 1));
                bus.mem_data  = DW'($urandom);
            end
            bus.reserve_valid = ($urandom_range(0, 2) == 0);
            bus.reserve_addr  = AW'($urandom_range(0, NR - 1));
            bus.AAddress = AW'($urandom_range(0, NR - 1));
            bus.BAddress = AW'($urandom_range(0, NR - 1));
            bus.a_use = 1'($urandom_range(0, 1));
            bus.b_use = 1'($urandom_range(0, 1));
            cycle_check("random");
        end
        @(negedge clk); idle(); cycle_check("rand_drain");
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (rf[r] !== m_rf[r]) begin failures++; $display("FAIL random_rf_r%0d got=%h exp=%h", r, rf[r], m_rf[r]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        model_reset();
        got_alu = 0; got_mem = 0;
        rf_init_done = 1'b0;
        @(posedge clk); #1;
        rf_init_done = 1'b1;
        test_reset();
        test_single_alu();
        test_contention();
        test_hazard();
        test_scoreboard();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result (alu_*) and memory load (mem_*). Uses round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending scoreboard: issue logic reserves a destination, and the read side stalls while either read address is pending.
- Sits between the execute/memory stages and RegisterFile. Its RegWrite/WriteAddress/DataIn outputs connect directly to RegisterFile; AAddress/BAddress are tapped from the read-address bus.

Parameters:
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 4, register address width
NUM_REGS, 16, register count; must equal 2**ADDR_WIDTH

Ports:
clk  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle (combinational)
alu_addr  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
mem_valid  in  1  memory writeback request
mem_ready  out  1  memory request granted this cycle (combinational)
mem_addr  in  ADDR_WIDTH  memory destination register
mem_data  in  DATA_WIDTH  load data
reserve_valid  in  1  issue logic marks a destination pending
reserve_addr  in  ADDR_WIDTH  register to reserve
reserve_ready  out  1  reservation accepted (combinational)
AAddress  in  ADDR_WIDTH  register file A read address
BAddress  in  ADDR_WIDTH  register file B read address
a_use  in  1  A operand is consumed this cycle
b_use  in  1  B operand is consumed this cycle
stall  out  1  read hazard on a used operand (combinational)
RegWrite  out  1  register file write enable (registered)
WriteAddress  out  ADDR_WIDTH  register file write address (registered)
DataIn  out  DATA_WIDTH  register file write data (registered)
pending  out  NUM_REGS  scoreboard bits (registered)
grant_src  out  1  source of the current RegWrite: 0=ALU, 1=MEM (registered)

Behaviour:
- Reset (synchronous, active-high):
  - RegWrite=0, WriteAddress=0, DataIn=0, grant_src=0, pending=0.
  - last_grant register = MEM, so the ALU wins the first contended cycle.
  - Reset asserted mid-operation discards any accepted-but-unwritten request. No RegWrite is issued in the cycle after reset.
  - While reset=1: alu_ready=mem_ready=reserve_ready=0; stall=0.
- Arbitration (combinational, at most one grant per cycle):
  - Only alu_valid: alu_ready=1.
  - Only mem_valid: mem_ready=1.
  - Both valid: grant goes to the source not in last_grant.
  - last_grant updates only on a grant. Idle cycles leave it unchanged.
  - Requesters hold valid/addr/data stable until ready. Deasserting valid without a grant is allowed; nothing is written.
- Write issue, 1-cycle latency:
  - A grant at edge N drives RegWrite=1 with the winning addr/data and grant_src during cycle N+1.
  - RegisterFile captures the data at edge N+1.
  - With no grant, RegWrite=0 the next cycle; WriteAddress/DataIn hold their previous values.
  - Back-to-back grants give continuous RegWrite=1, one write per cycle.
- Scoreboard:
  - reserve_ready = reserve_valid & ~pending[reserve_addr]. Reserving an already-pending register is refused; issue logic holds until accepted.
  - An accepted reservation sets pending[reserve_addr] at the next edge.
  - pending[WriteAddress] clears at the edge where RegWrite=1 (the same edge RegisterFile captures). The first cycle a read can see the new value is therefore the first cycle with the bit clear.
  - Same edge clears and reserves the same register: set wins (bit stays 1).
  - Writeback to a non-pending register is legal; it is written and the bit stays 0.
- Hazard:
  - stall = (a_use & pending[AAddress]) | (b_use & pending[BAddress]).
  - No bypass.
- Same destination from both sources in one cycle: both are written in arbitration order over two cycles. The last write wins in the register file.

Test Plan:
- Reset check: apply reset for 2 cycles with alu_valid=mem_valid=1 -> RegWrite=0, pending=16'h0000, both readys 0 throughout; the first grant after release goes to the ALU.
- Single ALU write: reserve R3, then alu_valid, alu_addr=3, alu_data=16'h1234 -> alu_ready=1 in the same cycle; next cycle RegWrite=1, WriteAddress=3, DataIn=16'h1234, grant_src=0; pending[3] goes 1 -> 0; read of A=3 returns 16'h1234.
- Contention: both valid for 4 cycles (ALU R1=16'h0011, MEM R2=16'h0022) -> grants alternate ALU, MEM, ALU, MEM; RegWrite stays high for 4 consecutive cycles.
- Hazard: reserve R5, AAddress=5, a_use=1 -> stall=1 until the cycle after the MEM write of R5=16'hBEEF, then stall=0 and A=16'hBEEF; a_use=0 with the same address -> stall=0.
- Scoreboard edges: reserve R7 twice -> second reserve_ready=0; reserve R7 on the same edge its write retires -> pending[7] stays 1.
- Mid-operation reset: grant an ALU write to R9 and assert reset on the next edge -> no RegWrite for R9, pending=0, R9 unchanged.
